// File: rtl/alu_pkg.sv
// Shared encodings for the execute-stage ALU: opcodes, flag bit positions and per-op flag masks.
package alu_pkg;

  localparam int unsigned OP_W   = 3;
  localparam int unsigned FLAG_W = 3;

  localparam int unsigned FLAG_C = 2;
  localparam int unsigned FLAG_L = 1;
  localparam int unsigned FLAG_Z = 0;

  typedef enum logic [OP_W-1:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_CMP = 3'd2,
    OP_AND = 3'd3,
    OP_OR  = 3'd4,
    OP_XOR = 3'd5,
    OP_SHL = 3'd6,
    OP_SHR = 3'd7
  } op_e;

  localparam logic [FLAG_W-1:0] SEL_NONE  = 3'b000;
  localparam logic [FLAG_W-1:0] SEL_ADD   = 3'b101;
  localparam logic [FLAG_W-1:0] SEL_SUB   = 3'b111;
  localparam logic [FLAG_W-1:0] SEL_LOGIC = 3'b001;
  localparam logic [FLAG_W-1:0] SEL_SHIFT = 3'b101;

  // Side-band payload presented to the flags register alongside the result.
  typedef struct packed {
    logic              we;
    logic [FLAG_W-1:0] sel;
    logic [FLAG_W-1:0] val;
  } flag_resp_t;

  function automatic logic [FLAG_W-1:0] op_sel(input op_e op);
    logic [FLAG_W-1:0] sel;
    case (op)
      OP_ADD:                 sel = SEL_ADD;
      OP_SUB, OP_CMP:         sel = SEL_SUB;
      OP_AND, OP_OR, OP_XOR:  sel = SEL_LOGIC;
      OP_SHL, OP_SHR:         sel = SEL_SHIFT;
      default:                sel = SEL_NONE;
    endcase
    return sel;
  endfunction

  // Flag values with deselected bits forced low.
  function automatic logic [FLAG_W-1:0] pack_flags(input logic [FLAG_W-1:0] sel,
                                                   input logic c, input logic l,
                                                   input logic z);
    logic [FLAG_W-1:0] v;
    v         = '0;
    v[FLAG_C] = c;
    v[FLAG_L] = l;
    v[FLAG_Z] = z;
    return v & sel;
  endfunction

endpackage

// File: rtl/alu_shifter.sv
// Iterative logical shifter: one bit per clock, reports the final value and last bit shifted out.
module alu_shifter
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 8,
  parameter int unsigned SHAMT_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               shr,
  input  logic [WIDTH-1:0]   a,
  input  logic [SHAMT_W-1:0] amt,
  output logic               done_c,
  output logic [WIDTH-1:0]   res_c,
  output logic               carry_c
);

  logic [WIDTH-1:0]   work_q;
  logic [SHAMT_W-1:0] cnt_q;
  logic               shr_q;
  logic               active_q;

  // Value and outgoing bit of the shift performed on the coming edge.
  always_comb begin
    res_c   = shr_q ? (work_q >> 1) : (work_q << 1);
    carry_c = shr_q ? work_q[0] : work_q[WIDTH-1];
    done_c  = active_q && (cnt_q == SHAMT_W'(1));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      work_q   <= '0;
      cnt_q    <= '0;
      shr_q    <= 1'b0;
      active_q <= 1'b0;
    end else if (start) begin
      work_q   <= a;
      cnt_q    <= amt;
      shr_q    <= shr;
      active_q <= 1'b1;
    end else if (active_q) begin
      work_q <= res_c;
      cnt_q  <= cnt_q - SHAMT_W'(1);
      if (done_c) begin
        active_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/alu_flag_gen.sv
// Execute-stage ALU feeding the carry/lessthan/zero flags register; shifts run iteratively.
module alu_flag_gen
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             result_we,
  output logic [2:0]       flag_sel,
  output logic [2:0]       flag_val
);

  localparam int unsigned SHAMT_W = $clog2(WIDTH);

  typedef enum logic {
    ST_IDLE,
    ST_SHIFT
  } state_e;

  state_e state_q, state_d;

  op_e                op_c;
  logic [SHAMT_W-1:0] shamt_c;
  logic               accept_c;
  logic               is_shift_c;
  logic               shift_start_c;
  logic [WIDTH:0]     sum_c;
  logic [WIDTH:0]     diff_c;
  logic               slt_c;

  logic [WIDTH-1:0]   alu_res_c;
  logic               alu_c_c;
  logic               alu_l_c;
  logic               alu_z_c;
  logic [FLAG_W-1:0]  alu_sel_c;

  logic               sh_done_c;
  logic [WIDTH-1:0]   sh_res_c;
  logic               sh_carry_c;

  logic               nxt_valid_c;
  logic [WIDTH-1:0]   nxt_result_c;
  flag_resp_t         nxt_resp_c;

  always_comb begin
    op_c          = op_e'(op);
    shamt_c       = b[SHAMT_W-1:0];
    accept_c      = in_valid && in_ready;
    is_shift_c    = (op_c == OP_SHL) || (op_c == OP_SHR);
    shift_start_c = accept_c && is_shift_c && (shamt_c != '0);
    sum_c         = {1'b0, a} + {1'b0, b};
    diff_c        = {1'b0, a} - {1'b0, b};
    slt_c         = $signed(a) < $signed(b);
  end

  // Single-cycle datapath; a zero-amount shift passes a through with no carry.
  always_comb begin
    alu_res_c = '0;
    alu_c_c   = 1'b0;
    alu_l_c   = 1'b0;
    case (op_c)
      OP_ADD: begin
        alu_res_c = sum_c[WIDTH-1:0];
        alu_c_c   = sum_c[WIDTH];
      end
      OP_SUB, OP_CMP: begin
        alu_res_c = diff_c[WIDTH-1:0];
        alu_c_c   = diff_c[WIDTH];
        alu_l_c   = slt_c;
      end
      OP_AND:  alu_res_c = a & b;
      OP_OR:   alu_res_c = a | b;
      OP_XOR:  alu_res_c = a ^ b;
      default: alu_res_c = a;
    endcase
    alu_z_c   = (alu_res_c == '0);
    alu_sel_c = op_sel(op_c);
  end

  alu_shifter #(
    .WIDTH   (WIDTH),
    .SHAMT_W (SHAMT_W)
  ) u_shifter (
    .clk     (clk),
    .rst_n   (rst_n),
    .start   (shift_start_c),
    .shr     (op_c == OP_SHR),
    .a       (a),
    .amt     (shamt_c),
    .done_c  (sh_done_c),
    .res_c   (sh_res_c),
    .carry_c (sh_carry_c)
  );

  // Next state and next registered outputs.
  always_comb begin
    state_d      = state_q;
    nxt_valid_c  = 1'b0;
    nxt_result_c = '0;
    nxt_resp_c   = '0;
    case (state_q)
      ST_IDLE: begin
        if (shift_start_c) begin
          state_d = ST_SHIFT;
        end else if (accept_c) begin
          nxt_valid_c    = 1'b1;
          nxt_result_c   = alu_res_c;
          nxt_resp_c.we  = (op_c != OP_CMP);
          nxt_resp_c.sel = alu_sel_c;
          nxt_resp_c.val = pack_flags(alu_sel_c, alu_c_c, alu_l_c, alu_z_c);
        end
      end
      ST_SHIFT: begin
        if (sh_done_c) begin
          state_d        = ST_IDLE;
          nxt_valid_c    = 1'b1;
          nxt_result_c   = sh_res_c;
          nxt_resp_c.we  = 1'b1;
          nxt_resp_c.sel = SEL_SHIFT;
          nxt_resp_c.val = pack_flags(SEL_SHIFT, sh_carry_c, 1'b0, sh_res_c == '0);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      result    <= '0;
      result_we <= 1'b0;
      flag_sel  <= '0;
      flag_val  <= '0;
    end else begin
      state_q   <= state_d;
      in_ready  <= (state_d == ST_IDLE);
      out_valid <= nxt_valid_c;
      result    <= nxt_result_c;
      result_we <= nxt_resp_c.we;
      flag_sel  <= nxt_resp_c.sel;
      flag_val  <= nxt_resp_c.val;
    end
  end

endmodule
